// File: rtl/cam_pkg.sv
// cam_pkg: shared sizes and types for the CAM storage/match stage.
`default_nettype none

package cam_pkg;

  localparam int CAM_ENTRIES = 32;
  localparam int CAM_DATA_W  = 32;
  localparam int CAM_IDX_W   = $clog2(CAM_ENTRIES);

  typedef logic [CAM_DATA_W-1:0]  cam_data_t;
  typedef logic [CAM_IDX_W-1:0]   cam_idx_t;
  typedef logic [CAM_ENTRIES-1:0] cam_vec_t;

endpackage

`default_nettype wire

// File: rtl/cam_row.sv
// cam_row: one CAM entry (data + valid), its update decode and key compare.
// Optional macro CAM_BYPASS_EN: compare against post-edge contents.
`default_nettype none

module cam_row
  import cam_pkg::*;
#(
  parameter int DATA_W = CAM_DATA_W,
  parameter int IDX_W  = CAM_IDX_W,
  parameter int INDEX  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_valid,
  input  logic [IDX_W-1:0]  write_index,
  input  logic [DATA_W-1:0] write_data,
  input  logic              invalidate_valid,
  input  logic [IDX_W-1:0]  invalidate_index,
  input  logic [DATA_W-1:0] search_data,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q,
  output logic              match
);

  localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(INDEX);

  logic wr_hit;
  logic inv_hit;

  assign wr_hit  = write_valid && (write_index == MY_IDX);
  assign inv_hit = invalidate_valid && (invalidate_index == MY_IDX);

  // A write to this entry overrides a same-cycle invalidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_hit) begin
      data_q  <= write_data;
      valid_q <= 1'b1;
    end else if (inv_hit) begin
      valid_q <= 1'b0;
    end
  end

`ifdef CAM_BYPASS_EN
  logic              eff_valid;
  logic [DATA_W-1:0] eff_data;

  always_comb begin
    eff_valid = valid_q;
    eff_data  = data_q;
    if (wr_hit) begin
      eff_valid = 1'b1;
      eff_data  = write_data;
    end else if (inv_hit) begin
      eff_valid = 1'b0;
    end
  end

  assign match = eff_valid && (eff_data == search_data);
`else
  assign match = valid_q && (data_q == search_data);
`endif

endmodule

`default_nettype wire

// File: rtl/cam_array.sv
// cam_array: 32-entry CAM storage with registered read port and match vector.
// Optional macro CAM_BYPASS_EN: searches see same-cycle writes/invalidates.
`default_nettype none

module cam_array
  import cam_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES,
  parameter int DATA_W  = CAM_DATA_W,
  parameter int IDX_W   = CAM_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_valid_i,
  input  logic [IDX_W-1:0]   write_index_i,
  input  logic [DATA_W-1:0]  write_data_i,
  input  logic               invalidate_valid_i,
  input  logic [IDX_W-1:0]   invalidate_index_i,
  input  logic               read_valid_i,
  input  logic [IDX_W-1:0]   read_index_i,
  output logic [DATA_W-1:0]  read_value_o,
  output logic               read_entry_valid_o,
  output logic               read_valid_o,
  input  logic               search_valid_i,
  input  logic [DATA_W-1:0]  search_data_i,
  output logic [ENTRIES-1:0] match_o,
  output logic               match_valid_o
);

  logic [DATA_W-1:0]  row_data [ENTRIES];
  logic [ENTRIES-1:0] row_valid;
  logic [ENTRIES-1:0] row_match;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_row
    cam_row #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .INDEX  (i)
    ) u_row (
      .clk              (clk),
      .rst              (rst),
      .write_valid      (write_valid_i),
      .write_index      (write_index_i),
      .write_data       (write_data_i),
      .invalidate_valid (invalidate_valid_i),
      .invalidate_index (invalidate_index_i),
      .search_data      (search_data_i),
      .data_q           (row_data[i]),
      .valid_q          (row_valid[i]),
      .match            (row_match[i])
    );
  end

  // Read samples pre-edge storage, so a same-cycle write returns old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_value_o       <= '0;
      read_entry_valid_o <= 1'b0;
      read_valid_o       <= 1'b0;
    end else begin
      read_valid_o <= read_valid_i;
      if (read_valid_i) begin
        read_value_o       <= row_data[read_index_i];
        read_entry_valid_o <= row_valid[read_index_i];
      end
    end
  end

  // Match vector is held between searches and drives the encoder from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_o       <= '0;
      match_valid_o <= 1'b0;
    end else begin
      match_valid_o <= search_valid_i;
      if (search_valid_i) begin
        match_o <= row_match;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cam_array.sv
// tb_cam_array: directed self-checking bench for cam_array.
`default_nettype none

module tb_cam_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_valid_i = 1'b0;
  logic [4:0]  write_index_i = '0;
  logic [31:0] write_data_i = '0;
  logic        invalidate_valid_i = 1'b0;
  logic [4:0]  invalidate_index_i = '0;
  logic        read_valid_i = 1'b0;
  logic [4:0]  read_index_i = '0;
  logic [31:0] read_value_o;
  logic        read_entry_valid_o;
  logic        read_valid_o;
  logic        search_valid_i = 1'b0;
  logic [31:0] search_data_i = '0;
  logic [31:0] match_o;
  logic        match_valid_o;

  int tests_run = 0;
  int tests_failed = 0;

  cam_array dut (
    .clk                (clk),
    .rst                (rst),
    .write_valid_i      (write_valid_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .invalidate_valid_i (invalidate_valid_i),
    .invalidate_index_i (invalidate_index_i),
    .read_valid_i       (read_valid_i),
    .read_index_i       (read_index_i),
    .read_value_o       (read_value_o),
    .read_entry_valid_o (read_entry_valid_o),
    .read_valid_o       (read_valid_o),
    .search_valid_i     (search_valid_i),
    .search_data_i      (search_data_i),
    .match_o            (match_o),
    .match_valid_o      (match_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Lowest set bit, as the downstream priority encoder would report it.
  function automatic logic [31:0] lowest_idx(input logic [31:0] v);
    lowest_idx = 32'hFFFF_FFFF;
    for (int i = 31; i >= 0; i--) if (v[i]) lowest_idx = i;
  endfunction

  task automatic idle();
    write_valid_i = 1'b0;
    invalidate_valid_i = 1'b0;
    read_valid_i = 1'b0;
    search_valid_i = 1'b0;
  endtask

  // Advance one clock; inputs driven before this are sampled at the edge.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] d);
    write_valid_i = 1'b1; write_index_i = idx; write_data_i = d;
  endtask

  task automatic do_inv(input logic [4:0] idx);
    invalidate_valid_i = 1'b1; invalidate_index_i = idx;
  endtask

  task automatic do_read(input logic [4:0] idx);
    read_valid_i = 1'b1; read_index_i = idx;
  endtask

  task automatic do_search(input logic [31:0] key);
    search_valid_i = 1'b1; search_data_i = key;
  endtask

  initial begin
    logic [31:0] exp_bypass_hit;
    logic [31:0] exp_bypass_inv;
`ifdef CAM_BYPASS_EN
    exp_bypass_hit = 32'h0000_0001;
    exp_bypass_inv = 32'h0000_0000;
`else
    exp_bypass_hit = 32'h0000_0000;
    exp_bypass_inv = 32'h0000_0001;
`endif

    // Reset state
    step(); step();
    check("rst_match", match_o, 32'h0);
    check("rst_match_valid", {31'h0, match_valid_o}, 32'h0);
    check("rst_read_valid", {31'h0, read_valid_o}, 32'h0);
    check("rst_read_value", read_value_o, 32'h0);
    rst = 1'b0;
    step();

    // Search and read after reset
    do_search(32'h0); do_read(5'd5);
    step();
    check("empty_match_valid", {31'h0, match_valid_o}, 32'h1);
    check("empty_match", match_o, 32'h0);
    check("empty_read_valid", {31'h0, read_valid_o}, 32'h1);
    check("empty_read_value", read_value_o, 32'h0);
    check("empty_read_entry_valid", {31'h0, read_entry_valid_o}, 32'h0);
    step();
    check("strobe_drop_match", {31'h0, match_valid_o}, 32'h0);
    check("strobe_drop_read", {31'h0, read_valid_o}, 32'h0);

    // Multiple hits
    do_write(5'd3, 32'hDEAD_BEEF); step();
    do_write(5'd17, 32'hDEAD_BEEF); step();
    do_search(32'hDEAD_BEEF); step();
    check("multi_match", match_o, 32'h0002_0008);
    check("multi_enc", lowest_idx(match_o), 32'd3);
    do_inv(5'd3); step();
    do_search(32'hDEAD_BEEF); step();
    check("after_inv_match", match_o, 32'h0002_0000);
    check("after_inv_enc", lowest_idx(match_o), 32'd17);
    step();
    check("match_hold", match_o, 32'h0002_0000);
    check("match_hold_strobe", {31'h0, match_valid_o}, 32'h0);
    do_search(32'h1111_1111); step();
    check("no_hit_match", match_o, 32'h0);

    // Same-index write + invalidate: write wins
    do_write(5'd31, 32'h1234_5678); do_inv(5'd31); step();
    do_read(5'd31); step();
    check("collide_value", read_value_o, 32'h1234_5678);
    check("collide_valid", {31'h0, read_entry_valid_o}, 32'h1);

    // Different indices: both take effect
    do_write(5'd5, 32'h0BAD_F00D); do_inv(5'd17); step();
    do_search(32'hDEAD_BEEF); do_read(5'd5); step();
    check("diff_idx_match", match_o, 32'h0);
    check("diff_idx_read", read_value_o, 32'h0BAD_F00D);
    check("diff_idx_read_valid", {31'h0, read_entry_valid_o}, 32'h1);

    // Read concurrent with write returns old data
    do_write(5'd31, 32'hCAFE_F00D); do_read(5'd31); step();
    check("rd_wr_old", read_value_o, 32'h1234_5678);
    do_read(5'd31); step();
    check("rd_wr_new", read_value_o, 32'hCAFE_F00D);

    // Invalidate keeps data
    do_inv(5'd5); step();
    do_read(5'd5); step();
    check("inv_keep_data", read_value_o, 32'h0BAD_F00D);
    check("inv_keep_valid", {31'h0, read_entry_valid_o}, 32'h0);

    // Write-search collision, then invalidate-search collision
    do_write(5'd0, 32'hA5A5_A5A5); do_search(32'hA5A5_A5A5); step();
    check("wr_search_collide", match_o, exp_bypass_hit);
    do_search(32'hA5A5_A5A5); step();
    check("wr_search_next", match_o, 32'h0000_0001);
    do_inv(5'd0); do_search(32'hA5A5_A5A5); step();
    check("inv_search_collide", match_o, exp_bypass_inv);
    do_write(5'd0, 32'hA5A5_A5A5); step();

    // Reset in the cycle after a search
    do_search(32'hA5A5_A5A5); step();
    check("pre_rst_match", match_o, 32'h0000_0001);
    rst = 1'b1;
    #1;
    check("mid_rst_match_valid", {31'h0, match_valid_o}, 32'h0);
    check("mid_rst_match", match_o, 32'h0);
    step();
    rst = 1'b0;
    do_search(32'hA5A5_A5A5); step();
    check("post_rst_search_a5", match_o, 32'h0);
    check("post_rst_strobe", {31'h0, match_valid_o}, 32'h1);
    do_search(32'hCAFE_F00D); do_read(5'd31); step();
    check("post_rst_search_cafe", match_o, 32'h0);
    check("post_rst_read", read_value_o, 32'h0);
    check("post_rst_read_valid", {31'h0, read_entry_valid_o}, 32'h0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cam_array.md
# cam_array

Storage and match stage of the CAM: 32 entries of 32-bit data, each with a valid bit. Supports write, invalidate, read and search. A search compares the key against every valid entry in parallel and registers a 32-bit one-hot-or-multi-hot match vector, which feeds the priority encoder's `priorityEnc_data_i` directly. Bit i of the match vector corresponds to entry i, so the encoder returns the lowest matching index.

## Interface
- `ENTRIES`, 32: number of entries. Must be 32 to mate with the priority encoder.
- `DATA_W`, 32: entry and key width.
- `IDX_W`, 5: index width, equal to $clog2(ENTRIES).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `write_valid_i` in 1: write request.
- `write_index_i` in IDX_W: target entry.
- `write_data_i` in DATA_W: data stored; entry marked valid.
- `invalidate_valid_i` in 1: invalidate request.
- `invalidate_index_i` in IDX_W: entry whose valid bit is cleared.
- `read_valid_i` in 1: read request.
- `read_index_i` in IDX_W: entry to read.
- `read_value_o` out DATA_W: read data.
- `read_entry_valid_o` out 1: valid bit of the read entry.
- `read_valid_o` out 1: read result strobe.
- `search_valid_i` in 1: search request.
- `search_data_i` in DATA_W: search key.
- `match_o` out ENTRIES: match vector, to the priority encoder.
- `match_valid_o` out 1: search result strobe.

## Operation
- Reset clears all entry data to 0 and all valid bits to 0. It also sets `read_value_o`, `read_entry_valid_o`, `read_valid_o`, `match_o` and `match_valid_o` to 0.
- A reset asserted mid-operation aborts any in-flight read or search. No strobe is produced for it.
- **Write:** at the clock edge, store `write_data_i` into the entry and set its valid bit. Overwriting a valid entry is legal.
- **Invalidate:** at the clock edge, clear the entry's valid bit. Data is retained. Invalidating an already-invalid entry is a no-op.
- **Write and invalidate to the same index in one cycle:** the write wins; the entry ends valid with the new data.
- **Write and invalidate to different indices in one cycle:** both take effect.
- **Read:** captures the entry's pre-edge data and valid bit. A read concurrent with a write to the same index returns the old contents.
- **Search:** `match_o[i]` is set when entry i is valid and its data equals `search_data_i`.
  - Searches use pre-edge storage, except as modified by `CAM_BYPASS_EN`.
  - `match_o` holds its last value until the next search; it updates only when `search_valid_i` is asserted.
- A search with no hits produces `match_o` = 0 with `match_valid_o` = 1. The downstream encoder then reports invalid.
- Read, write, invalidate and search may all be asserted in the same cycle; all are independent.
- There is no state machine beyond the storage and output registers. No backpressure exists: one request of each type per cycle is accepted.

## Timing
- Write and invalidate take effect at the edge where they are sampled. They are visible to a read or search issued on the next cycle.
- Read latency is 1 cycle: `read_valid_o` pulses one cycle after `read_valid_i`. `read_value_o` and `read_entry_valid_o` hold until the next read.
- Search latency is 1 cycle: `match_valid_o` pulses one cycle after `search_valid_i`.
- Back-to-back searches give one result per cycle.
- The match vector is a registered output, so the priority encoder's combinational path starts from a flop.

## Configuration
- **`CAM_BYPASS_EN` defined:** a search in the same cycle as a write to entry k treats entry k as valid with `write_data_i`. It also treats any entry invalidated that cycle as invalid, unless the same entry is also being written, in which case the write rule applies. Result: the search sees post-edge contents.
- **`CAM_BYPASS_EN` undefined:** a search sees pre-edge contents only. Software must allow one cycle between an update and a dependent search.

## Structure
- Package `cam_pkg` holds:
  - constants `CAM_ENTRIES`, `CAM_DATA_W`, `CAM_IDX_W`;
  - typedefs `cam_data_t` (logic [CAM_DATA_W-1:0]), `cam_idx_t` (logic [CAM_IDX_W-1:0]) and `cam_vec_t` (logic [CAM_ENTRIES-1:0]).
- Sub-module `cam_row` is instantiated ENTRIES times via generate. It holds:
  - one entry's data register and valid bit;
  - the write/invalidate decode for its index;
  - the equality compare, producing one match bit.
  The top level registers the vector and handles the read mux.

## Test plan
- **Reset then search:** after reset, search key 0x0000_0000 -> `match_o` = 0 and `match_valid_o` = 1 one cycle later. All read outputs return 0.
- **Multiple hits:** write 0xDEAD_BEEF to entries 3 and 17, then search 0xDEAD_BEEF -> `match_o` = 0x0002_0008; the encoder returns index 3. Invalidate entry 3 and search again -> `match_o` = 0x0002_0000, and the encoder returns 17.
- **Same-index collision:** same-cycle write of 0x1234_5678 and invalidate, both to entry 31. Then read 31 -> `read_value_o` = 0x1234_5678 and `read_entry_valid_o` = 1.
- **Write-search collision:** write 0xA5A5_A5A5 to entry 0 while searching 0xA5A5_A5A5 in the same cycle.
  - With `CAM_BYPASS_EN`: `match_o` = 0x0000_0001.
  - Without it: `match_o` = 0.
- **Reset mid-search:** assert `rst` in the cycle after `search_valid_i` -> `match_valid_o` = 0 and `match_o` = 0. A following search finds no previously written entries.
